cnn_accel_mac_pipe: RTL and testbench

Parametrised, pipelined multiply-accumulate unit for the CNN accelerator datapath. It is the successor to the fixed-width single-cycle multipliers. Each beat carries two operands plus a per-beat signed/unsigned mode flag. Products are summed into a saturating accumulator, and one result is emitted per packet (the packet ends on the beat with in_last). Valid/ready handshakes on both sides allow it to sit between the line-buffer/weight fetch and the activation stage.

---
 rtl/cnn_accel_mac_pipe_if.sv | 32 +++
 rtl/cnn_accel_mac_pipe.sv | 148 ++++++++++++++
 tb/tb_cnn_accel_mac_pipe.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_accel_mac_pipe_if.sv
// Beat/result bus of the pipelined MAC unit.
//
// Handshake: a transfer happens on a rising clock edge where valid && ready
// are both high. A source that raises valid keeps valid and its payload
// stable until that edge. ready may depend combinationally on the other
// side's state, but valid never depends on ready.
interface cnn_accel_mac_pipe_if #(
    parameter int DIN0_WIDTH = 5,
    parameter int DIN1_WIDTH = 7,
    parameter int ACC_WIDTH  = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIN0_WIDTH-1:0] din0;
    logic [DIN1_WIDTH-1:0] din1;
    logic                  is_signed;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_WIDTH-1:0]  dout;
    logic                  ovf;

    modport master (
        output in_valid, din0, din1, is_signed, in_last, out_ready,
        input  in_ready, out_valid, dout, ovf
    );

    modport slave (
        input  in_valid, din0, din1, is_signed, in_last, out_ready,
        output in_ready, out_valid, dout, ovf
    );
endinterface

// File: rtl/cnn_accel_mac_pipe.sv
// Pipelined multiply-accumulate with per-beat signed/unsigned mode and a
// saturating accumulator. One result per packet (packet ends on in_last).
// The whole pipe advances together; it stalls only while a finished result
// is held and not taken. ACC_WIDTH must be >= DIN0_WIDTH+DIN1_WIDTH+1 and
// NUM_STAGE must lie in 1..4.
module cnn_accel_mac_pipe #(
    parameter int DIN0_WIDTH = 5,
    parameter int DIN1_WIDTH = 7,
    parameter int ACC_WIDTH  = 16,
    parameter int NUM_STAGE  = 2
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    cnn_accel_mac_pipe_if.slave bus
);
    localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic advance;

    // Operand stages: index 0 is the capture register, the multiply sits
    // after index NUM_STAGE-1.
    logic [DIN0_WIDTH-1:0] a_q [NUM_STAGE];
    logic [DIN1_WIDTH-1:0] b_q [NUM_STAGE];
    logic [NUM_STAGE-1:0]  sgn_q;
    logic [NUM_STAGE-1:0]  last_q;
    logic [NUM_STAGE-1:0]  vld_q;

    logic signed [DIN0_WIDTH:0]   mul_a;
    logic signed [DIN1_WIDTH:0]   mul_b;
    logic signed [PROD_WIDTH+1:0] prod_full;

    logic signed [ACC_WIDTH-1:0] prod_q;
    logic                        prod_last_q;
    logic                        prod_vld_q;

    logic signed [ACC_WIDTH-1:0] acc_q;
    logic                        first_q;
    logic                        sat_q;

    logic signed [ACC_WIDTH:0]   sum;
    logic signed [ACC_WIDTH-1:0] clamped;
    logic                        step_ovf;
    logic                        sat_base;

    logic                        out_valid_q;
    logic signed [ACC_WIDTH-1:0] dout_q;
    logic                        ovf_q;

    assign advance       = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.ovf       = ovf_q;

    // Operand pipeline: capture the beat, then shift it toward the multiplier.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < NUM_STAGE; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
            sgn_q  <= '0;
            last_q <= '0;
            vld_q  <= '0;
        end else if (advance) begin
            a_q[0]    <= bus.din0;
            b_q[0]    <= bus.din1;
            sgn_q[0]  <= bus.is_signed;
            last_q[0] <= bus.in_last;
            vld_q[0]  <= bus.in_valid;
            for (int i = 1; i < NUM_STAGE; i++) begin
                a_q[i]    <= a_q[i-1];
                b_q[i]    <= b_q[i-1];
                sgn_q[i]  <= sgn_q[i-1];
                last_q[i] <= last_q[i-1];
                vld_q[i]  <= vld_q[i-1];
            end
        end
    end

    // One extra top bit per operand: sign copy in signed mode, zero otherwise,
    // so a single signed multiply covers both modes.
    always_comb begin
        mul_a     = {sgn_q[NUM_STAGE-1] & a_q[NUM_STAGE-1][DIN0_WIDTH-1], a_q[NUM_STAGE-1]};
        mul_b     = {sgn_q[NUM_STAGE-1] & b_q[NUM_STAGE-1][DIN1_WIDTH-1], b_q[NUM_STAGE-1]};
        prod_full = mul_a * mul_b;
    end

    // Last pipeline stage: register the product extended to accumulator width.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            prod_q      <= '0;
            prod_last_q <= 1'b0;
            prod_vld_q  <= 1'b0;
        end else if (advance) begin
            prod_q      <= ACC_WIDTH'(prod_full);
            prod_last_q <= last_q[NUM_STAGE-1];
            prod_vld_q  <= vld_q[NUM_STAGE-1];
        end
    end

    // Guarded add and clamp; the first beat of a packet starts from zero.
    always_comb begin
        sat_base = first_q ? 1'b0 : sat_q;
        sum      = (first_q ? '0 : {acc_q[ACC_WIDTH-1], acc_q}) + {prod_q[ACC_WIDTH-1], prod_q};
        step_ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
        clamped  = sum[ACC_WIDTH-1:0];
        if (step_ovf) begin
            clamped = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
    end

    // Accumulator state: continue from the clamped value, rearm on last beat.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_q   <= '0;
            first_q <= 1'b1;
            sat_q   <= 1'b0;
        end else if (advance && prod_vld_q) begin
            if (prod_last_q) begin
                acc_q   <= '0;
                first_q <= 1'b1;
                sat_q   <= 1'b0;
            end else begin
                acc_q   <= clamped;
                first_q <= 1'b0;
                sat_q   <= sat_base | step_ovf;
            end
        end
    end

    // Result register: load on a last beat, otherwise drop once taken.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            ovf_q       <= 1'b0;
        end else if (advance) begin
            out_valid_q <= prod_vld_q && prod_last_q;
            if (prod_vld_q && prod_last_q) begin
                dout_q <= clamped;
                ovf_q  <= sat_base | step_ovf;
            end
        end
    end
endmodule

// File: tb/tb_cnn_accel_mac_pipe.sv
// Bench for cnn_accel_mac_pipe: main instance with NUM_STAGE=2 plus two
// instances (NUM_STAGE=1 and 4) that see the same beats during the
// throughput phase. A packet-level arithmetic model predicts every result.
module tb_cnn_accel_mac_pipe;
    localparam int D0 = 5;
    localparam int D1 = 7;
    localparam int AW = 16;
    localparam longint MAXV = (64'sd1 <<< (AW-1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (AW-1));

    // ---------------- clock / reset ----------------
    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    cnn_accel_mac_pipe_if #(.DIN0_WIDTH(D0), .DIN1_WIDTH(D1), .ACC_WIDTH(AW)) bus ();
    cnn_accel_mac_pipe_if #(.DIN0_WIDTH(D0), .DIN1_WIDTH(D1), .ACC_WIDTH(AW)) bus1 ();
    cnn_accel_mac_pipe_if #(.DIN0_WIDTH(D0), .DIN1_WIDTH(D1), .ACC_WIDTH(AW)) bus4 ();

    cnn_accel_mac_pipe #(.DIN0_WIDTH(D0), .DIN1_WIDTH(D1), .ACC_WIDTH(AW), .NUM_STAGE(2))
        dut (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bus));
    cnn_accel_mac_pipe #(.DIN0_WIDTH(D0), .DIN1_WIDTH(D1), .ACC_WIDTH(AW), .NUM_STAGE(1))
        dut1 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bus1));
    cnn_accel_mac_pipe #(.DIN0_WIDTH(D0), .DIN1_WIDTH(D1), .ACC_WIDTH(AW), .NUM_STAGE(4))
        dut4 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bus4));

    bit thr_en = 1'b0;
    bit lat_mode = 1'b0;
    int rdy_mode = 0;

    assign bus1.in_valid  = bus.in_valid & thr_en;
    assign bus1.din0      = bus.din0;
    assign bus1.din1      = bus.din1;
    assign bus1.is_signed = bus.is_signed;
    assign bus1.in_last   = bus.in_last;
    assign bus1.out_ready = bus.out_ready;
    assign bus4.in_valid  = bus.in_valid & thr_en;
    assign bus4.din0      = bus.din0;
    assign bus4.din1      = bus.din1;
    assign bus4.is_signed = bus.is_signed;
    assign bus4.in_last   = bus.in_last;
    assign bus4.out_ready = bus.out_ready;

    // Downstream ready: 0 = always ready, 1 = random, 2 = never ready.
    always @(posedge ap_clk) begin
        #1;
        case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
        endcase
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_fail = 0;
    int taken = 0;

    logic [AW:0] exp_q[$];
    logic [AW:0] exp1_q[$];
    logic [AW:0] exp4_q[$];
    int edge_q[$];
    int edge1_q[$];
    int edge4_q[$];

    longint m_acc = 0;
    bit     m_first = 1'b1;
    bit     m_sat = 1'b0;
    longint m_dout = 0;
    bit     m_ovf = 1'b0;
    int     m_cnt = 0;
    bit     prev_stall = 1'b0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Packet-level model: plain integer arithmetic per accepted beat.
    task automatic model_beat(input logic [D0-1:0] a, input logic [D1-1:0] b, input logic s, input logic l, input int edge_no);
        longint av, bv, sum;
        bit sb;
        logic [AW:0] v;
        av = longint'(a);
        bv = longint'(b);
        if (s && a[D0-1]) av = av - (64'sd1 <<< D0);
        if (s && b[D1-1]) bv = bv - (64'sd1 <<< D1);
        sum = (m_first ? 64'sd0 : m_acc) + av * bv;
        sb = m_first ? 1'b0 : m_sat;
        if (sum > MAXV) begin
            sum = MAXV;
            sb = 1'b1;
        end else if (sum < MINV) begin
            sum = MINV;
            sb = 1'b1;
        end
        if (l) begin
            m_dout = sum;
            m_ovf = sb;
            m_cnt++;
            v = {sb, sum[AW-1:0]};
            exp_q.push_back(v);
            edge_q.push_back(edge_no);
            if (thr_en) begin
                exp1_q.push_back(v);
                edge1_q.push_back(edge_no);
                exp4_q.push_back(v);
                edge4_q.push_back(edge_no);
            end
            m_acc = 0;
            m_first = 1'b1;
            m_sat = 1'b0;
        end else begin
            m_acc = sum;
            m_sat = sb;
            m_first = 1'b0;
        end
    endtask

    task automatic check_inst(input int idx, input logic ov, input logic ord, input logic [AW-1:0] d, input logic o);
        logic [AW:0] e;
        int ed;
        int ns;
        bit empty;
        e = '0;
        ed = 0;
        case (idx)
            0: begin ns = 2; empty = (exp_q.size() == 0); if (!empty) begin e = exp_q[0]; ed = edge_q[0]; end end
            1: begin ns = 1; empty = (exp1_q.size() == 0); if (!empty) begin e = exp1_q[0]; ed = edge1_q[0]; end end
            default: begin ns = 4; empty = (exp4_q.size() == 0); if (!empty) begin e = exp4_q[0]; ed = edge4_q[0]; end end
        endcase
        if (ov) begin
            if (empty) begin
                n_vec++;
                n_fail++;
                $display("FAIL spurious_result[ns=%0d]: got dout %0d, expected no result", ns, $signed(d));
            end else begin
                check($sformatf("dout[ns=%0d]", ns), $signed(d), $signed(e[AW-1:0]));
                check($sformatf("ovf[ns=%0d]", ns), o, e[AW]);
                if (ord) begin
                    if (lat_mode) check($sformatf("latency[ns=%0d]", ns), cyc, ed + ns + 1);
                    if (idx == 0) taken++;
                    case (idx)
                        0: begin void'(exp_q.pop_front()); void'(edge_q.pop_front()); end
                        1: begin void'(exp1_q.pop_front()); void'(edge1_q.pop_front()); end
                        default: begin void'(exp4_q.pop_front()); void'(edge4_q.pop_front()); end
                    endcase
                end
            end
        end
    endtask

    // Compare process: mid-cycle, all inputs and outputs are settled.
    always @(negedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            exp_q.delete(); exp1_q.delete(); exp4_q.delete();
            edge_q.delete(); edge1_q.delete(); edge4_q.delete();
            m_acc = 0;
            m_first = 1'b1;
            m_sat = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check_inst(0, bus.out_valid, bus.out_ready, bus.dout, bus.ovf);
            check_inst(1, bus1.out_valid, bus1.out_ready, bus1.dout, bus1.ovf);
            check_inst(2, bus4.out_valid, bus4.out_ready, bus4.dout, bus4.ovf);
            check("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
            if (prev_stall) check("held_valid", bus.out_valid, 1'b1);
            prev_stall = bus.out_valid && !bus.out_ready;
            if (bus.in_valid && bus.in_ready)
                model_beat(bus.din0, bus.din1, bus.is_signed, bus.in_last, cyc + 1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic [D0-1:0] a, input logic [D1-1:0] b, input logic s, input logic l);
        bit done;
        int guard;
        done = 1'b0;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.din0 = a;
        bus.din1 = b;
        bus.is_signed = s;
        bus.in_last = l;
        while (!done) begin
            @(negedge ap_clk);
            done = bus.in_ready;
            @(posedge ap_clk);
            #1;
            guard++;
            if (!done && guard > 200) begin
                fail_now("accept_timeout");
                done = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || exp1_q.size() != 0 || exp4_q.size() != 0) && guard < 500) begin
            @(posedge ap_clk);
            guard++;
        end
        if (guard >= 500) fail_now("drain_timeout");
        repeat (2) @(posedge ap_clk);
        #1;
    endtask

    task automatic pin(input string name, input longint d, input bit o);
        check({name, "_model_dout"}, m_dout, d);
        check({name, "_model_ovf"}, m_ovf, o);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int t0;
        int c0;
        bus.in_valid = 1'b0;
        bus.din0 = '0;
        bus.din1 = '0;
        bus.is_signed = 1'b0;
        bus.in_last = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_dout", bus.dout, 0);
        check("rst_ovf", bus.ovf, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        lat_mode = 1'b1;

        // Unsigned max operands
        send_beat(5'd31, 7'd127, 1'b0, 1'b1);
        wait_drain();
        pin("umax", 3937, 1'b0);

        // Signed -1 * -64
        send_beat(5'h1F, 7'h40, 1'b1, 1'b1);
        wait_drain();
        pin("sneg", 64, 1'b0);

        // Signed 3-beat packet with a bubble after the first beat
        send_beat(5'd3, 7'd4, 1'b1, 1'b0);
        @(posedge ap_clk);
        #1;
        send_beat(5'h1E, 7'd5, 1'b1, 1'b0);
        send_beat(5'd7, 7'd1, 1'b1, 1'b1);
        wait_drain();
        pin("s3beat", 9, 1'b0);

        // Mixed modes in one packet
        send_beat(5'd31, 7'd1, 1'b0, 1'b0);
        send_beat(5'h1F, 7'd1, 1'b1, 1'b1);
        wait_drain();
        pin("mixed", 30, 1'b0);

        // Positive saturation
        for (int i = 0; i < 9; i++) send_beat(5'd31, 7'd127, 1'b0, 1'(i == 8));
        wait_drain();
        pin("satmax", 32767, 1'b1);

        // Negative saturation
        for (int i = 0; i < 33; i++) send_beat(5'h10, 7'h3F, 1'b1, 1'(i == 32));
        wait_drain();
        pin("satmin", -32768, 1'b1);

        // Fresh packet clears sticky flag
        send_beat(5'd2, 7'd3, 1'b0, 1'b1);
        wait_drain();
        pin("after_sat", 6, 1'b0);

        // Accumulation continues from the clamped value
        for (int i = 0; i < 9; i++) send_beat(5'd31, 7'd127, 1'b0, 1'b0);
        send_beat(5'h1F, 7'h3F, 1'b1, 1'b1);
        wait_drain();
        pin("from_clamp", 32704, 1'b1);

        // Backpressure with random downstream ready
        lat_mode = 1'b0;
        rdy_mode = 1;
        t0 = taken;
        c0 = m_cnt;
        for (int k = 1; k <= 10; k++) send_beat(5'(k), 7'd1, 1'b0, 1'b1);
        wait_drain();
        rdy_mode = 0;
        pin("bp_last", 10, 1'b0);
        check("bp_model_count", m_cnt - c0, 10);
        check("bp_taken_count", taken - t0, 10);

        // Reset mid-packet while a result is held
        repeat (3) @(posedge ap_clk);
        #1;
        rdy_mode = 2;
        send_beat(5'd1, 7'd1, 1'b0, 1'b1);
        send_beat(5'd5, 7'd5, 1'b0, 1'b0);
        send_beat(5'd5, 7'd5, 1'b0, 1'b0);
        repeat (3) @(posedge ap_clk);
        #2;
        ap_rst_n = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_in_ready", bus.in_ready, 1'b1);
        #1;
        ap_rst_n = 1'b1;
        rdy_mode = 0;
        @(posedge ap_clk);
        #1;
        send_beat(5'd2, 7'd3, 1'b0, 1'b1);
        wait_drain();
        pin("post_rst", 6, 1'b0);

        // Throughput: back-to-back one-beat packets on all three depths
        lat_mode = 1'b1;
        thr_en = 1'b1;
        t0 = taken;
        for (int k = 1; k <= 12; k++) send_beat(5'(k), 7'd3, 1'b0, 1'b1);
        wait_drain();
        thr_en = 1'b0;
        pin("thr_last", 36, 1'b0);
        check("thr_taken_count", taken - t0, 12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
